// File: rtl/bfly_feed.sv
// bfly_feed: buffers the first half of a frame in a delay line, then presents
// each second-half beat alongside its first-half partner (FIFO order) so a
// downstream radix-2 butterfly sees both operands on the same cycle.
module bfly_feed #(
  parameter int SIG   = 1,
  parameter int INT   = 2,
  parameter int FLT   = 6,
  parameter int WIDTH = SIG + INT + FLT,
  parameter int DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    din_valid,
  input  logic signed [WIDTH-1:0] din_i   [16],
  input  logic signed [WIDTH-1:0] din_q   [16],
  output logic                    bfly_en,
  output logic signed [WIDTH-1:0] dout1_i [16],
  output logic signed [WIDTH-1:0] dout1_q [16],
  output logic signed [WIDTH-1:0] dout2_i [16],
  output logic signed [WIDTH-1:0] dout2_q [16],
  output logic                    frame_done,
  output logic                    err
);

  localparam int LANES = 16;
  localparam int CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {FILL = 1'b0, PAIR = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    bfly_en_q, bfly_en_d;
  logic                    frame_done_q, frame_done_d;
  logic                    err_q, err_d;
  logic signed [WIDTH-1:0] d1i_q [LANES], d1i_d [LANES];
  logic signed [WIDTH-1:0] d1q_q [LANES], d1q_d [LANES];
  logic signed [WIDTH-1:0] d2i_q [LANES], d2i_d [LANES];
  logic signed [WIDTH-1:0] d2q_q [LANES], d2q_d [LANES];
  // Delay line is addressed by cnt: FILL writes slot k, PAIR reads slot k,
  // which gives FIFO pairing without separate read/write pointers.
  logic signed [WIDTH-1:0] dli_q [DEPTH][LANES], dli_d [DEPTH][LANES];
  logic signed [WIDTH-1:0] dlq_q [DEPTH][LANES], dlq_d [DEPTH][LANES];
  logic                    last_beat;

  assign last_beat = (cnt_q == CW'(DEPTH - 1));

  // Next-state: fill the delay line, then pair; a stall mid-pair aborts the frame.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bfly_en_d    = 1'b0;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    d1i_d        = d1i_q;
    d1q_d        = d1q_q;
    d2i_d        = d2i_q;
    d2q_d        = d2q_q;
    dli_d        = dli_q;
    dlq_d        = dlq_q;
    case (state_q)
      FILL: begin
        if (din_valid) begin
          dli_d[cnt_q] = din_i;
          dlq_d[cnt_q] = din_q;
          if (last_beat) begin
            state_d = PAIR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PAIR: begin
        if (din_valid) begin
          bfly_en_d = 1'b1;
          d1i_d     = din_i;
          d1q_d     = din_q;
          d2i_d     = dli_q[cnt_q];
          d2q_d     = dlq_q[cnt_q];
          if (last_beat) begin
            frame_done_d = 1'b1;
            state_d      = FILL;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          // Downstream cannot tolerate a gap inside a half; drop the frame.
          err_d   = 1'b1;
          state_d = FILL;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // State, outputs and delay line; reset clears everything including samples.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      bfly_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        d1i_q[l] <= '0;
        d1q_q[l] <= '0;
        d2i_q[l] <= '0;
        d2q_q[l] <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          dli_q[d][l] <= '0;
          dlq_q[d][l] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bfly_en_q    <= bfly_en_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      d1i_q        <= d1i_d;
      d1q_q        <= d1q_d;
      d2i_q        <= d2i_d;
      d2q_q        <= d2q_d;
      dli_q        <= dli_d;
      dlq_q        <= dlq_d;
    end
  end

  assign bfly_en    = bfly_en_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign dout1_i    = d1i_q;
  assign dout1_q    = d1q_q;
  assign dout2_i    = d2i_q;
  assign dout2_q    = d2q_q;

endmodule

// File: tb/tb_bfly_feed.sv
// Testbench for bfly_feed (DEPTH=4, WIDTH=9): directed frames with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_bfly_feed;

  localparam int W     = 9;
  localparam int DEPTH = 4;
  localparam int BW    = 2 * 16 * W;

  logic                clk = 1'b0;
  logic                rstn;
  logic                din_valid;
  logic signed [W-1:0] din_i   [16];
  logic signed [W-1:0] din_q   [16];
  logic                bfly_en;
  logic signed [W-1:0] dout1_i [16];
  logic signed [W-1:0] dout1_q [16];
  logic signed [W-1:0] dout2_i [16];
  logic signed [W-1:0] dout2_q [16];
  logic                frame_done;
  logic                err;

  int n_tests = 0;
  int n_fail  = 0;

  bfly_feed #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid),
    .din_i(din_i), .din_q(din_q),
    .bfly_en(bfly_en),
    .dout1_i(dout1_i), .dout1_q(dout1_q),
    .dout2_i(dout2_i), .dout2_q(dout2_q),
    .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  // Whole beats as flat vectors: {Q lanes, I lanes}
  logic [BW-1:0] din_pk, d1_pk, d2_pk;
  always_comb begin
    din_pk = '0;
    d1_pk  = '0;
    d2_pk  = '0;
    for (int l = 0; l < 16; l++) begin
      din_pk[l*W +: W]      = din_i[l];
      din_pk[(16+l)*W +: W] = din_q[l];
      d1_pk[l*W +: W]       = dout1_i[l];
      d1_pk[(16+l)*W +: W]  = dout1_q[l];
      d2_pk[l*W +: W]       = dout2_i[l];
      d2_pk[(16+l)*W +: W]  = dout2_q[l];
    end
  end

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk_s(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference model: first half queued, second half pops partners in order.
  logic [BW-1:0] hold_q [$];
  bit            pairing = 0;
  logic          m_en = 0, m_fd = 0, m_err = 0;
  logic [BW-1:0] m_d1 = '0, m_d2 = '0;

  always @(posedge clk) begin
    if (rstn) begin
      hold_q.delete();
      pairing = 0;
      m_en = 0; m_fd = 0; m_err = 0; m_d1 = '0; m_d2 = '0;
    end else begin
      m_en = 0; m_fd = 0; m_err = 0;
      if (!pairing) begin
        if (din_valid) begin
          hold_q.push_back(din_pk);
          if (hold_q.size() == DEPTH) pairing = 1;
        end
      end else if (din_valid) begin
        m_en = 1;
        m_d1 = din_pk;
        m_d2 = hold_q.pop_front();
        if (hold_q.size() == 0) begin
          m_fd = 1;
          pairing = 0;
        end
      end else begin
        m_err = 1;
        hold_q.delete();
        pairing = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rstn) begin
      chk("rst_en", {{(BW-1){1'b0}}, bfly_en}, '0);
      chk("rst_fd", {{(BW-1){1'b0}}, frame_done}, '0);
      chk("rst_err", {{(BW-1){1'b0}}, err}, '0);
      chk("rst_d1", d1_pk, '0);
      chk("rst_d2", d2_pk, '0);
    end else begin
      chk("m_en", {{(BW-1){1'b0}}, bfly_en}, {{(BW-1){1'b0}}, m_en});
      chk("m_fd", {{(BW-1){1'b0}}, frame_done}, {{(BW-1){1'b0}}, m_fd});
      chk("m_err", {{(BW-1){1'b0}}, err}, {{(BW-1){1'b0}}, m_err});
      chk("m_d1", d1_pk, m_d1);
      chk("m_d2", d2_pk, m_d2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int base);
    din_valid = v;
    for (int l = 0; l < 16; l++) begin
      din_i[l] = W'(base + 32 * l);
      din_q[l] = W'(-base - l);
    end
  endtask

  task automatic drive_rand(input bit v);
    din_valid = v;
    for (int l = 0; l < 16; l++) begin
      din_i[l] = W'($urandom);
      din_q[l] = W'($urandom);
    end
  endtask

  task automatic idle();
    din_valid = 1'b0;
    step();
  endtask

  // Eight valid beats base+0..base+7; second half must pair with first half.
  task automatic run_frame(input string nm, input int base);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, base + k);
      step();
      if (k >= 4) begin
        chk_s({nm, "_en"}, W'(bfly_en), W'(1));
        chk_s({nm, "_d1"}, dout1_i[0], W'(base + k));
        chk_s({nm, "_d2"}, dout2_i[0], W'(base + k - 4));
        chk_s({nm, "_fd"}, W'(frame_done), W'(k == 7));
      end else begin
        chk_s({nm, "_en_fill"}, W'(bfly_en), W'(0));
      end
    end
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    step();
    rstn = 1'b0;
  endtask

  initial begin
    rstn = 1'b1;
    drive(1'b0, 0);
    step();
    step();
    chk_s("reset_en", W'(bfly_en), W'(0));
    chk_s("reset_d1", dout1_i[3], W'(0));
    rstn = 1'b0;
    idle();

    // Basic frame: lane0 1..8
    run_frame("basic", 1);
    idle();

    // Gap of 3 idle cycles between fill beats 2 and 3
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, k);
      step();
      chk_s("gap_en", W'(bfly_en), W'(k >= 5));
      if (k >= 5) chk_s("gap_d2", dout2_i[0], W'(k - 4));
      if (k == 3) begin
        for (int g = 0; g < 3; g++) begin
          idle();
          chk_s("gap_idle_en", W'(bfly_en), W'(0));
        end
      end
    end
    idle();

    // Stall after 2 pair beats
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 20 + k);
      step();
    end
    idle();
    chk_s("stall_err", W'(err), W'(1));
    chk_s("stall_en", W'(bfly_en), W'(0));
    idle();
    chk_s("stall_err_pulse", W'(err), W'(0));
    run_frame("after_stall", 40);

    // Two frames back to back
    run_frame("b2b_a", 60);
    run_frame("b2b_b", 80);
    idle();

    // Asynchronous reset during pair beat 1
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 100 + k);
      step();
    end
    chk_s("pre_rst_en", W'(bfly_en), W'(1));
    drive(1'b1, 105);
    #2;
    rstn = 1'b1;
    #1;
    chk_s("async_rst_en", W'(bfly_en), W'(0));
    chk_s("async_rst_d1", dout1_i[0], W'(0));
    chk_s("async_rst_d2q", dout2_q[7], W'(0));
    step();
    rstn = 1'b0;
    run_frame("after_rst", 120);
    idle();

    // Extremes on all lanes
    for (int k = 0; k < 8; k++) begin
      din_valid = 1'b1;
      for (int l = 0; l < 16; l++) begin
        din_i[l] = -9'sd256;
        din_q[l] = 9'sd255;
      end
      step();
      if (k >= 4) begin
        chk_s("ext_d2i", dout2_i[15], 9'h100);
        chk_s("ext_d2q", dout2_q[0], 9'h0FF);
        chk_s("ext_d1i", dout1_i[8], 9'h100);
      end
    end
    idle();

    // Randomized traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        drive_rand($urandom_range(0, 11) != 0);
        step();
      end
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
